// File: rtl/shifter_seq.sv
// shifter_seq: multi-cycle rotate/shift unit, one logarithmic stage (shift by 2^s) per clock.
// Latency: result valid SHW+1 cycles after the accepting handshake (1 cycle for amt=0 when
//          SHIFTER_SEQ_ZERO_BYPASS_EN is defined); one transaction in flight at a time.
// Backpressure: in_ready only in IDLE; out_data/out_valid held in DONE until out_ready.
module shifter_seq #(
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [1:0]                 op,
    input  logic [$clog2(WIDTH)-1:0]   amt,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       busy
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0]   WIDTH_L = (SHW+1)'(WIDTH);
    localparam logic [SHW-1:0] LAST_S  = SHW'(SHW - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [1:0]       op_q, op_d;
    logic [SHW-1:0]   amt_q, amt_d;
    logic [SHW-1:0]   s_q, s_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    logic             accept;
    logic [WIDTH-1:0] stage_res;

    // One stage of the selected operation by k = 2^s; amounts never exceed WIDTH/2 here.
    function automatic logic [WIDTH-1:0] apply_stage(input logic [WIDTH-1:0] w,
                                                      input logic [1:0]       o,
                                                      input logic [SHW-1:0]   s);
        logic [SHW:0]             k;
        logic signed [WIDTH-1:0]  ws;
        logic [WIDTH-1:0]         r;
        k  = (SHW+1)'(1) << s;
        ws = w;
        r  = '0;
        case (o)
            OP_ROL:  r = (w << k) | (w >> (WIDTH_L - k));
            OP_SLL:  r = w << k;
            OP_SRA:  r = ws >>> k;
            default: r = w >> k;
        endcase
        return r;
    endfunction

    // in_ready is forced low while reset is asserted so no request is lost to the reset.
    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_data  = out_data_q;

    // Current stage result: only stages whose amount bit is set modify the work register.
    always_comb begin
        stage_res = work_q;
        if (amt_q[s_q]) begin
            stage_res = apply_stage(work_q, op_q, s_q);
        end
    end

    // Next-state logic for the IDLE -> SHIFT -> DONE sequence.
    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        op_d       = op_q;
        amt_d      = amt_q;
        s_d        = s_q;
        out_data_d = out_data_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    work_d  = in_data;
                    op_d    = op;
                    amt_d   = amt;
                    s_d     = '0;
                    state_d = ST_SHIFT;
`ifdef SHIFTER_SEQ_ZERO_BYPASS_EN
                    // Zero amount is an identity for every op, so skip the stage walk.
                    if (amt == '0) begin
                        out_data_d = in_data;
                        state_d    = ST_DONE;
                    end
`endif
                end
            end
            ST_SHIFT: begin
                work_d = stage_res;
                s_d    = s_q + 1'b1;
                if (s_q == LAST_S) begin
                    out_data_d = stage_res;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset discards any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            work_q     <= '0;
            op_q       <= '0;
            amt_q      <= '0;
            s_q        <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            op_q       <= op_d;
            amt_q      <= amt_d;
            s_q        <= s_d;
            out_data_q <= out_data_d;
        end
    end

endmodule
